// File: rtl/rob_pkg.sv
// Shared reorder-buffer constants and types: tag width, depth, register index and data widths.
`ifndef ROB_PKG_SV
`define ROB_PKG_SV
package rob_pkg;
   localparam int ROB_TAG_W = 4;
   localparam int ROB_DEPTH = 1 << ROB_TAG_W;
   localparam int REG_W     = 5;
   localparam int DATA_W    = 32;

   typedef logic [ROB_TAG_W-1:0] tag_t;
   typedef logic [ROB_TAG_W:0]   count_t;
   typedef logic [REG_W-1:0]     reg_t;
   typedef logic [DATA_W-1:0]    data_t;

   localparam reg_t NO_REG = '0;
endpackage
`endif

// File: rtl/rob_if.sv
// Dispatcher / CDB / commit bundle of the reorder buffer; the ROB sits on the slave side.
interface rob_if;
   import rob_pkg::*;

   logic  rdy;
   logic  issue_sig;
   reg_t  issue_rd;
   logic  issue_is_branch;
   logic  issue_pred_taken;
   logic  issue_is_store;
   tag_t  issue_rob_tag;
   logic  rob_full;

   tag_t  query_tag1;
   tag_t  query_tag2;
   logic  query_ready1;
   logic  query_ready2;
   data_t query_val1;
   data_t query_val2;

   logic  cdb_sig;
   tag_t  cdb_tag;
   data_t cdb_val;
   logic  cdb_taken;
   data_t cdb_next_pc;

   logic  commit_sig;
   reg_t  commit_reg;
   data_t commit_val;
   tag_t  commit_rob_tag;
   logic  commit_store;
   logic  clear;
   data_t redirect_pc;

   modport master (
      output rdy, issue_sig, issue_rd, issue_is_branch, issue_pred_taken, issue_is_store,
      output query_tag1, query_tag2,
      output cdb_sig, cdb_tag, cdb_val, cdb_taken, cdb_next_pc,
      input  issue_rob_tag, rob_full, query_ready1, query_ready2, query_val1, query_val2,
      input  commit_sig, commit_reg, commit_val, commit_rob_tag, commit_store, clear, redirect_pc
   );

   modport slave (
      input  rdy, issue_sig, issue_rd, issue_is_branch, issue_pred_taken, issue_is_store,
      input  query_tag1, query_tag2,
      input  cdb_sig, cdb_tag, cdb_val, cdb_taken, cdb_next_pc,
      output issue_rob_tag, rob_full, query_ready1, query_ready2, query_val1, query_val2,
      output commit_sig, commit_reg, commit_val, commit_rob_tag, commit_store, clear, redirect_pc
   );
endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order tag allocation, CDB result capture, one in-order retirement per
// cycle, and a full flush with PC redirect when a retiring branch was mispredicted.
module rob
   import rob_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   rob_if.slave bus
);
   logic [ROB_DEPTH-1:0] busy;
   logic [ROB_DEPTH-1:0] ready;
   logic [ROB_DEPTH-1:0] is_branch;
   logic [ROB_DEPTH-1:0] pred_taken;
   logic [ROB_DEPTH-1:0] taken;
   logic [ROB_DEPTH-1:0] is_store;
   reg_t  rd      [ROB_DEPTH];
   data_t val     [ROB_DEPTH];
   data_t next_pc [ROB_DEPTH];

   tag_t   head;
   tag_t   tail;
   count_t count;

   logic full;
   logic do_commit;
   logic mispredict;
   logic do_issue;
   logic cdb_hit;

   always_comb begin
      full       = (count == count_t'(ROB_DEPTH));
      do_commit  = bus.rdy && busy[head] && ready[head];
      mispredict = do_commit && is_branch[head] && (taken[head] != pred_taken[head]);
      // A flush in this cycle throws away whatever the dispatcher is issuing alongside it.
      do_issue   = bus.rdy && bus.issue_sig && !full && !mispredict;
      cdb_hit    = bus.rdy && bus.cdb_sig && busy[bus.cdb_tag];
   end

   assign bus.issue_rob_tag = tail;
   assign bus.rob_full      = full;

   // Operand lookup forwards a result that is on the CDB in this very cycle.
   always_comb begin
      bus.query_ready1 = ready[bus.query_tag1];
      bus.query_val1   = val[bus.query_tag1];
      bus.query_ready2 = ready[bus.query_tag2];
      bus.query_val2   = val[bus.query_tag2];
      if (bus.cdb_sig && (bus.cdb_tag == bus.query_tag1)) begin
         bus.query_ready1 = 1'b1;
         bus.query_val1   = bus.cdb_val;
      end
      if (bus.cdb_sig && (bus.cdb_tag == bus.query_tag2)) begin
         bus.query_ready2 = 1'b1;
         bus.query_val2   = bus.cdb_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy               <= '0;
         ready              <= '0;
         head               <= '0;
         tail               <= '0;
         count              <= '0;
         bus.commit_sig     <= 1'b0;
         bus.commit_store   <= 1'b0;
         bus.clear          <= 1'b0;
         bus.commit_reg     <= NO_REG;
         bus.commit_val     <= '0;
         bus.commit_rob_tag <= '0;
         bus.redirect_pc    <= '0;
      end else begin
         // Every term below already carries rdy, so a stalled cycle holds state and drops pulses.
         bus.commit_sig   <= do_commit;
         bus.commit_store <= do_commit && is_store[head];
         bus.clear        <= mispredict;
         if (do_commit) begin
            bus.commit_reg     <= rd[head];
            bus.commit_val     <= val[head];
            bus.commit_rob_tag <= head;
         end
         if (mispredict) begin
            bus.redirect_pc <= next_pc[head];
            busy            <= '0;
            ready           <= '0;
            head            <= '0;
            tail            <= '0;
            count           <= '0;
         end else begin
            if (cdb_hit) begin
               ready[bus.cdb_tag] <= 1'b1;
            end
            if (do_commit) begin
               busy[head]  <= 1'b0;
               ready[head] <= 1'b0;
               head        <= head + 1'b1;
            end
            if (do_issue) begin
               busy[tail]  <= 1'b1;
               ready[tail] <= 1'b0;
               tail        <= tail + 1'b1;
            end
            count <= count + count_t'(do_issue) - count_t'(do_commit);
         end
      end
   end

   // Payload fields are only meaningful while busy/ready say so, hence no reset.
   always_ff @(posedge clk) begin
      if (do_issue) begin
         rd[tail]         <= bus.issue_rd;
         is_branch[tail]  <= bus.issue_is_branch;
         pred_taken[tail] <= bus.issue_pred_taken;
         is_store[tail]   <= bus.issue_is_store;
      end
      if (cdb_hit) begin
         val[bus.cdb_tag]     <= bus.cdb_val;
         taken[bus.cdb_tag]   <= bus.cdb_taken;
         next_pc[bus.cdb_tag] <= bus.cdb_next_pc;
      end
   end
endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: vector table, directed corner sequences, and a randomized run
// against a program-order queue model of the reorder buffer.
module tb_rob;
   import rob_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rob_if bus();
   rob dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.rdy = 1'b1;
      bus.issue_sig = 1'b0;
      bus.issue_rd = 5'd0;
      bus.issue_is_branch = 1'b0;
      bus.issue_pred_taken = 1'b0;
      bus.issue_is_store = 1'b0;
      bus.query_tag1 = 4'd0;
      bus.query_tag2 = 4'd0;
      bus.cdb_sig = 1'b0;
      bus.cdb_tag = 4'd0;
      bus.cdb_val = 32'd0;
      bus.cdb_taken = 1'b0;
      bus.cdb_next_pc = 32'd0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic issue(input logic [4:0] rd);
      idle();
      bus.issue_sig = 1'b1;
      bus.issue_rd = rd;
      step();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        iss;
      logic [4:0]  rd;
      logic        cdb;
      logic [3:0]  ctag;
      logic [31:0] cval;
      logic        e_commit;
      logic [4:0]  e_reg;
      logic [31:0] e_val;
      logic [3:0]  e_tag;
      logic [3:0]  e_itag;
      logic        e_full;
   } vec_t;
   vec_t tbl[13];

   // ---------------- reference model ----------------
   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  rd;
      logic        br;
      logic        pt;
      logic        st;
      logic        done;
      logic        tk;
      logic [31:0] v;
      logic [31:0] npc;
   } ent_t;
   ent_t q[$];
   ent_t h;
   ent_t e;
   int next_tag;
   logic m_sig, m_store, m_clr, m_com, m_mis, m_full;
   logic [4:0] m_reg;
   logic [31:0] m_val, m_rpc;
   logic [3:0] m_ctag;
   logic exp_r1, exp_r2;
   logic [31:0] exp_v1, exp_v2;
   int idx, cdb_pct;
   logic br;

   task automatic model_reset();
      q.delete();
      next_tag = 0;
      m_sig = 1'b0; m_store = 1'b0; m_clr = 1'b0;
      m_reg = 5'd0; m_val = 32'd0; m_rpc = 32'd0; m_ctag = 4'd0;
   endtask

   function automatic void qexp(input logic [3:0] t, output logic r, output logic [31:0] v);
      r = 1'b0;
      v = 32'd0;
      foreach (q[k]) begin
         if (q[k].tag == t && q[k].done) begin
            r = 1'b1;
            v = q[k].v;
         end
      end
      if (bus.cdb_sig && bus.cdb_tag == t) begin
         r = 1'b1;
         v = bus.cdb_val;
      end
   endfunction

   // Advance the model by one clock edge using the inputs currently on the bus.
   task automatic model_edge();
      if (bus.rdy) begin
         m_full = (q.size() == 16);
         m_com = (q.size() > 0) && q[0].done;
         m_mis = 1'b0;
         m_store = 1'b0;
         m_sig = m_com;
         if (m_com) begin
            h = q.pop_front();
            m_reg = h.rd;
            m_val = h.v;
            m_ctag = h.tag;
            m_store = h.st;
            m_mis = h.br && (h.tk != h.pt);
            if (m_mis) m_rpc = h.npc;
         end
         if (bus.cdb_sig) begin
            foreach (q[k]) begin
               if (q[k].tag == bus.cdb_tag) begin
                  q[k].done = 1'b1;
                  q[k].v = bus.cdb_val;
                  q[k].tk = bus.cdb_taken;
                  q[k].npc = bus.cdb_next_pc;
               end
            end
         end
         m_clr = m_mis;
         if (m_mis) begin
            q.delete();
            next_tag = 0;
         end else if (bus.issue_sig && !m_full) begin
            e.tag = 4'(next_tag);
            e.rd = bus.issue_rd;
            e.br = bus.issue_is_branch;
            e.pt = bus.issue_pred_taken;
            e.st = bus.issue_is_store;
            e.done = 1'b0;
            e.tk = 1'b0;
            e.v = 32'd0;
            e.npc = 32'd0;
            q.push_back(e);
            next_tag = (next_tag + 1) % 16;
         end
      end else begin
         m_sig = 1'b0;
         m_store = 1'b0;
         m_clr = 1'b0;
      end
   endtask

   initial begin
      tbl[0]  = '{1'b1, 5'd5, 1'b0, 4'd0, 32'h0,    1'b0, 5'd0, 32'h0,    4'd0, 4'd1, 1'b0};
      tbl[1]  = '{1'b0, 5'd0, 1'b1, 4'd0, 32'h1234, 1'b0, 5'd0, 32'h0,    4'd0, 4'd1, 1'b0};
      tbl[2]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    1'b1, 5'd5, 32'h1234, 4'd0, 4'd1, 1'b0};
      tbl[3]  = '{1'b1, 5'd1, 1'b0, 4'd0, 32'h0,    1'b0, 5'd0, 32'h0,    4'd0, 4'd2, 1'b0};
      tbl[4]  = '{1'b1, 5'd2, 1'b0, 4'd0, 32'h0,    1'b0, 5'd0, 32'h0,    4'd0, 4'd3, 1'b0};
      tbl[5]  = '{1'b1, 5'd3, 1'b0, 4'd0, 32'h0,    1'b0, 5'd0, 32'h0,    4'd0, 4'd4, 1'b0};
      tbl[6]  = '{1'b0, 5'd0, 1'b1, 4'd3, 32'h33,   1'b0, 5'd0, 32'h0,    4'd0, 4'd4, 1'b0};
      tbl[7]  = '{1'b0, 5'd0, 1'b1, 4'd2, 32'h22,   1'b0, 5'd0, 32'h0,    4'd0, 4'd4, 1'b0};
      tbl[8]  = '{1'b0, 5'd0, 1'b1, 4'd1, 32'h11,   1'b0, 5'd0, 32'h0,    4'd0, 4'd4, 1'b0};
      tbl[9]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    1'b1, 5'd1, 32'h11,   4'd1, 4'd4, 1'b0};
      tbl[10] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    1'b1, 5'd2, 32'h22,   4'd2, 4'd4, 1'b0};
      tbl[11] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    1'b1, 5'd3, 32'h33,   4'd3, 4'd4, 1'b0};
      tbl[12] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    1'b0, 5'd0, 32'h0,    4'd0, 4'd4, 1'b0};

      // Reset values, sampled while reset is held.
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("reset.commit_sig", 32'(bus.commit_sig), 32'd0);
      chk("reset.commit_store", 32'(bus.commit_store), 32'd0);
      chk("reset.clear", 32'(bus.clear), 32'd0);
      chk("reset.commit_reg", 32'(bus.commit_reg), 32'd0);
      chk("reset.commit_val", bus.commit_val, 32'd0);
      chk("reset.commit_rob_tag", 32'(bus.commit_rob_tag), 32'd0);
      chk("reset.redirect_pc", bus.redirect_pc, 32'd0);
      chk("reset.issue_rob_tag", 32'(bus.issue_rob_tag), 32'd0);
      chk("reset.rob_full", 32'(bus.rob_full), 32'd0);
      rst_n = 1'b1;

      // Table: basic latency and out-of-order completion, in-order retirement.
      for (int i = 0; i < 13; i++) begin
         idle();
         bus.issue_sig = tbl[i].iss;
         bus.issue_rd = tbl[i].rd;
         bus.cdb_sig = tbl[i].cdb;
         bus.cdb_tag = tbl[i].ctag;
         bus.cdb_val = tbl[i].cval;
         step();
         chk($sformatf("vec%0d.commit_sig", i), 32'(bus.commit_sig), 32'(tbl[i].e_commit));
         if (tbl[i].e_commit) begin
            chk($sformatf("vec%0d.commit_reg", i), 32'(bus.commit_reg), 32'(tbl[i].e_reg));
            chk($sformatf("vec%0d.commit_val", i), bus.commit_val, tbl[i].e_val);
            chk($sformatf("vec%0d.commit_rob_tag", i), 32'(bus.commit_rob_tag), 32'(tbl[i].e_tag));
         end
         chk($sformatf("vec%0d.issue_rob_tag", i), 32'(bus.issue_rob_tag), 32'(tbl[i].e_itag));
         chk($sformatf("vec%0d.rob_full", i), 32'(bus.rob_full), 32'(tbl[i].e_full));
         $display("vec %0d: issue=%0d cdb=%0d tag=%0d -> commit=%0d reg=%0d val=%08h",
                  i, tbl[i].iss, tbl[i].cdb, tbl[i].ctag, bus.commit_sig, bus.commit_reg, bus.commit_val);
      end

      // Full buffer, ignored 17th issue, wrap of the tail.
      do_reset();
      for (int i = 0; i < 16; i++) issue(5'(i + 1));
      chk("full.rob_full", 32'(bus.rob_full), 32'd1);
      chk("full.issue_rob_tag", 32'(bus.issue_rob_tag), 32'd0);
      issue(5'd31);
      chk("full.17th_rob_full", 32'(bus.rob_full), 32'd1);
      chk("full.17th_issue_rob_tag", 32'(bus.issue_rob_tag), 32'd0);
      idle(); bus.cdb_sig = 1'b1; bus.cdb_tag = 4'd0; bus.cdb_val = 32'h7; step();
      idle(); step();
      chk("full.commit_sig", 32'(bus.commit_sig), 32'd1);
      chk("full.commit_reg", 32'(bus.commit_reg), 32'd1);
      chk("full.after_commit_full", 32'(bus.rob_full), 32'd0);
      chk("full.after_commit_tag", 32'(bus.issue_rob_tag), 32'd0);
      issue(5'd9);
      chk("full.wrap_issue_rob_tag", 32'(bus.issue_rob_tag), 32'd1);
      chk("full.wrap_rob_full", 32'(bus.rob_full), 32'd1);
      $display("seq full: wrap issue done, issue_rob_tag=%0d", bus.issue_rob_tag);

      // Mispredicted jump: link written, flush, discarded same-cycle issue.
      do_reset();
      idle(); bus.issue_sig = 1'b1; bus.issue_rd = 5'd1; bus.issue_is_branch = 1'b1; step();
      issue(5'd2); issue(5'd3); issue(5'd4);
      idle(); bus.cdb_sig = 1'b1; bus.cdb_tag = 4'd0; bus.cdb_val = 32'h44;
      bus.cdb_taken = 1'b1; bus.cdb_next_pc = 32'h100; step();
      idle(); bus.issue_sig = 1'b1; bus.issue_rd = 5'd7; step();
      chk("mis.commit_sig", 32'(bus.commit_sig), 32'd1);
      chk("mis.commit_reg", 32'(bus.commit_reg), 32'd1);
      chk("mis.commit_val", bus.commit_val, 32'h44);
      chk("mis.clear", 32'(bus.clear), 32'd1);
      chk("mis.redirect_pc", bus.redirect_pc, 32'h100);
      chk("mis.issue_rob_tag", 32'(bus.issue_rob_tag), 32'd0);
      idle(); step();
      chk("mis.clear_one_cycle", 32'(bus.clear), 32'd0);
      chk("mis.no_commit_after", 32'(bus.commit_sig), 32'd0);
      issue(5'd8);
      chk("mis.reissue_tag", 32'(bus.issue_rob_tag), 32'd1);
      idle(); bus.cdb_sig = 1'b1; bus.cdb_tag = 4'd0; bus.cdb_val = 32'h55; step();
      idle(); step();
      chk("mis.new_commit_reg", 32'(bus.commit_reg), 32'd8);
      chk("mis.new_commit_val", bus.commit_val, 32'h55);
      idle(); step();
      chk("mis.old_entries_gone", 32'(bus.commit_sig), 32'd0);
      $display("seq mispredict: redirect checked, refill tag 0 committed");

      // Combinational query forwarding from the CDB, then from the entry.
      do_reset();
      for (int i = 0; i < 4; i++) issue(5'(i + 10));
      idle(); bus.cdb_sig = 1'b1; bus.cdb_tag = 4'd3; bus.cdb_val = 32'hABCD;
      bus.query_tag1 = 4'd3; bus.query_tag2 = 4'd2; #1;
      chk("query.fwd_ready1", 32'(bus.query_ready1), 32'd1);
      chk("query.fwd_val1", bus.query_val1, 32'hABCD);
      chk("query.ready2", 32'(bus.query_ready2), 32'd0);
      step();
      bus.cdb_sig = 1'b0; #1;
      chk("query.entry_ready1", 32'(bus.query_ready1), 32'd1);
      chk("query.entry_val1", bus.query_val1, 32'hABCD);
      $display("seq query: forward and stored value checked");

      // Store retirement after a rdy=0 window that must change nothing.
      do_reset();
      idle(); bus.issue_sig = 1'b1; bus.issue_is_store = 1'b1; step();
      for (int i = 0; i < 3; i++) begin
         idle(); bus.rdy = 1'b0; bus.issue_sig = 1'b1; bus.issue_rd = 5'd9;
         bus.cdb_sig = 1'b1; bus.cdb_tag = 4'd0; bus.cdb_val = 32'h77; step();
         chk($sformatf("stall%0d.commit_sig", i), 32'(bus.commit_sig), 32'd0);
         chk($sformatf("stall%0d.commit_store", i), 32'(bus.commit_store), 32'd0);
         chk($sformatf("stall%0d.clear", i), 32'(bus.clear), 32'd0);
         chk($sformatf("stall%0d.issue_rob_tag", i), 32'(bus.issue_rob_tag), 32'd1);
      end
      idle(); #1;
      chk("stall.tag0_not_ready", 32'(bus.query_ready1), 32'd0);
      bus.cdb_sig = 1'b1; bus.cdb_tag = 4'd0; bus.cdb_val = 32'h77; step();
      idle(); step();
      chk("store.commit_sig", 32'(bus.commit_sig), 32'd1);
      chk("store.commit_store", 32'(bus.commit_store), 32'd1);
      chk("store.commit_reg", 32'(bus.commit_reg), 32'd0);
      idle(); step();
      chk("store.pulse_ends", 32'(bus.commit_store), 32'd0);
      $display("seq store: commit_store seen after stall window");

      // Randomized run against the queue model, with one asynchronous reset mid-stream.
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 900; cyc++) begin
         if (cyc == 450) begin
            rst_n = 1'b0;
            #1;
            chk("rand.async_rst_tag", 32'(bus.issue_rob_tag), 32'd0);
            chk("rand.async_rst_full", 32'(bus.rob_full), 32'd0);
            chk("rand.async_rst_commit", 32'(bus.commit_sig), 32'd0);
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
         end
         idle();
         bus.rdy = ($urandom_range(0, 9) != 0);
         bus.issue_sig = ($urandom_range(0, 1) == 1);
         br = ($urandom_range(0, 5) == 0);
         bus.issue_is_branch = br;
         bus.issue_pred_taken = ($urandom_range(0, 1) == 1);
         bus.issue_is_store = !br && ($urandom_range(0, 4) == 0);
         bus.issue_rd = bus.issue_is_store ? 5'd0 : 5'($urandom_range(0, 31));
         cdb_pct = (((cyc / 100) % 2) == 1) ? 75 : 15;
         if (q.size() > 0 && int'($urandom_range(0, 99)) < cdb_pct) begin
            idx = int'($urandom_range(0, q.size() - 1));
            bus.cdb_sig = 1'b1;
            bus.cdb_tag = q[idx].tag;
            bus.cdb_taken = ($urandom_range(0, 7) == 0) ? !q[idx].pt : q[idx].pt;
         end else if ($urandom_range(0, 19) == 0) begin
            bus.cdb_sig = 1'b1;
            bus.cdb_tag = 4'($urandom);
            bus.cdb_taken = ($urandom_range(0, 1) == 1);
         end
         bus.cdb_val = $urandom;
         bus.cdb_next_pc = $urandom;
         bus.query_tag1 = ($urandom_range(0, 3) == 0) ? bus.cdb_tag : 4'($urandom);
         bus.query_tag2 = 4'($urandom);
         #1;
         qexp(bus.query_tag1, exp_r1, exp_v1);
         qexp(bus.query_tag2, exp_r2, exp_v2);
         chk("rand.query_ready1", 32'(bus.query_ready1), 32'(exp_r1));
         if (exp_r1) chk("rand.query_val1", bus.query_val1, exp_v1);
         chk("rand.query_ready2", 32'(bus.query_ready2), 32'(exp_r2));
         if (exp_r2) chk("rand.query_val2", bus.query_val2, exp_v2);
         model_edge();
         step();
         chk("rand.commit_sig", 32'(bus.commit_sig), 32'(m_sig));
         chk("rand.commit_store", 32'(bus.commit_store), 32'(m_store));
         chk("rand.clear", 32'(bus.clear), 32'(m_clr));
         chk("rand.commit_reg", 32'(bus.commit_reg), 32'(m_reg));
         chk("rand.commit_val", bus.commit_val, m_val);
         chk("rand.commit_rob_tag", 32'(bus.commit_rob_tag), 32'(m_ctag));
         chk("rand.redirect_pc", bus.redirect_pc, m_rpc);
         chk("rand.issue_rob_tag", 32'(bus.issue_rob_tag), 32'(next_tag));
         chk("rand.rob_full", 32'(bus.rob_full), 32'(q.size() == 16));
         if (m_sig) begin
            $display("rand cyc=%0d commit tag=%0d reg=%0d val=%08h store=%0d clear=%0d",
                     cyc, m_ctag, m_reg, m_val, m_store, m_clr);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
